// File: rtl/tipi_reg_seq_pkg.sv
// Shared definitions for the TIPI register-port sequencer: op codes,
// FSM state encoding and frame-length constants.
package tipi_reg_seq_pkg;

  // Host command op codes. Bit 1 selects the TI-origin registers (reads),
  // bit 0 selects data over control. Both bits drive r_rt/r_cd directly.
  typedef enum logic [1:0] {
    OP_WRC = 2'b00,
    OP_WRD = 2'b01,
    OP_RTC = 2'b10,
    OP_RTD = 2'b11
  } op_t;

  // Sequencer states. LOAD is used by reads only, LATCH by writes only.
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SETUP = 3'd1,
    ST_LOAD  = 3'd2,
    ST_SHIFT = 3'd3,
    ST_LATCH = 3'd4,
    ST_FIN   = 3'd5
  } state_t;

  // A write shifts one bit per pulse.
  localparam int WRITE_PULSES = 8;
  // A read needs one extra pulse because the CPLD output mux is registered.
  localparam int READ_PULSES  = 9;

  // Reads are the TI-origin register ops (TC/TD).
  function automatic logic op_is_read(input op_t op);
    return op[1];
  endfunction

endpackage

// File: rtl/tipi_reg_seq_phase_timer.sv
// Half-period timer for the serial port. Counts CLK_DIV clk cycles per
// r_clk half-period while enabled and flags the last cycle of each half.
module tipi_reg_seq_phase_timer #(
  parameter int CLK_DIV = 4
) (
  input  logic clk,
  input  logic reset_n,
  input  logic en,
  output logic half_end,
  output logic sample_slot
);

  localparam int CW = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
  localparam logic [CW-1:0] TERM = CW'(CLK_DIV - 1);

  logic [CW-1:0] cnt;

  // Free-running divider; held at zero while disabled so every frame
  // starts on a fresh half-period.
  always_ff @(posedge clk) begin
    if (!reset_n || !en) begin
      cnt <= '0;
    end else if (cnt == TERM) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

  // The last clk of a half is both the advance point for the sequencer
  // and the point where r_din has been stable longest.
  assign half_end    = en && (cnt == TERM);
  assign sample_slot = en && (cnt == TERM);

endmodule

// File: rtl/tipi_reg_seq.sv
// Sequencer for the RPi-side serial register port of the TIPI CPLD.
// Runs one-byte host commands (write RC/RD, read TC/TD) and a background
// TC poller that flags changes of TC. Host commands take priority.
//
// Handshake: cmd_req is level-sensitive and only sampled in IDLE; the
// requester keeps it high until it sees cmd_busy, which rises the cycle
// after acceptance and falls together with the one-cycle cmd_done pulse.
//
// Frame shape (each pulse = one low half followed by one high half):
//   write: SETUP(low) | 8 shift pulses | LATCH pulse (r_le=1) | FIN
//   read : SETUP(low) | LOAD pulse (r_le=1) | 9 shift pulses | FIN
// r_rt/r_cd/r_le/r_dout only change at the start of a low half (or in FIN,
// together with the final falling edge), so they are stable for a full
// half-period on both sides of every r_clk rise.
module tipi_reg_seq
  import tipi_reg_seq_pkg::*;
#(
  parameter int CLK_DIV     = 4,
  parameter int POLL_CYCLES = 1024
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       cmd_req,
  input  logic [1:0] cmd_op,
  input  logic [7:0] cmd_wdata,
  output logic       cmd_busy,
  output logic       cmd_done,
  output logic [7:0] cmd_rdata,
  input  logic       poll_en,
  output logic       tc_changed,
  input  logic       tc_clear,
  output logic [7:0] tc_last,
  output logic       r_clk,
  output logic       r_rt,
  output logic       r_cd,
  output logic       r_le,
  output logic       r_dout,
  input  logic       r_din
);

  localparam int PW = $clog2(POLL_CYCLES + 1);
  localparam logic [PW-1:0] POLL_TERM = PW'(POLL_CYCLES - 1);

  // Sequencer state is kept as a named signal so checkers can bind to it.
  state_t        state;
  op_t           op;
  logic          host;      // current op came from the host (not the poller)
  logic          hi;        // currently in the high half of a pulse
  logic [3:0]    bit_cnt;   // pulse index within SHIFT, from 0
  logic [7:0]    wsr;       // outgoing write byte, MSB first
  logic [7:0]    rsr;       // incoming read byte, MSB first
  logic [PW-1:0] poll_cnt;

  logic half_end;
  logic sample_slot;
  logic timer_en;
  logic poll_due;

  assign timer_en = (state == ST_SETUP) || (state == ST_LOAD) ||
                    (state == ST_SHIFT) || (state == ST_LATCH);
  assign poll_due = poll_en && (poll_cnt == POLL_TERM);

  tipi_reg_seq_phase_timer #(
    .CLK_DIV (CLK_DIV)
  ) u_timer (
    .clk         (clk),
    .reset_n     (reset_n),
    .en          (timer_en),
    .half_end    (half_end),
    .sample_slot (sample_slot)
  );

  // Single sequencer FSM with registered port outputs and the poll counter.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state      <= ST_IDLE;
      op         <= OP_WRC;
      host       <= 1'b0;
      hi         <= 1'b0;
      bit_cnt    <= '0;
      wsr        <= '0;
      rsr        <= '0;
      poll_cnt   <= '0;
      cmd_busy   <= 1'b0;
      cmd_done   <= 1'b0;
      cmd_rdata  <= '0;
      tc_changed <= 1'b0;
      tc_last    <= '0;
      r_clk      <= 1'b0;
      r_rt       <= 1'b0;
      r_cd       <= 1'b0;
      r_le       <= 1'b0;
      r_dout     <= 1'b0;
    end else begin
      cmd_done <= 1'b0;
      // A poll setting tc_changed in FIN is assigned later and so wins.
      if (tc_clear) begin
        tc_changed <= 1'b0;
      end

      case (state)
        ST_IDLE: begin
          if (cmd_req) begin
            op       <= op_t'(cmd_op);
            wsr      <= cmd_wdata;
            host     <= 1'b1;
            cmd_busy <= 1'b1;
            state    <= ST_SETUP;
            hi       <= 1'b0;
            r_clk    <= 1'b0;
            r_le     <= 1'b0;
            r_rt     <= cmd_op[1];
            r_cd     <= cmd_op[0];
            // A poll that fell due in this same cycle keeps its terminal
            // count and runs in the next IDLE cycle.
            if (!poll_due) begin
              poll_cnt <= '0;
            end
          end else if (poll_due) begin
            op       <= OP_RTC;
            host     <= 1'b0;
            state    <= ST_SETUP;
            hi       <= 1'b0;
            r_clk    <= 1'b0;
            r_le     <= 1'b0;
            r_rt     <= 1'b1;
            r_cd     <= 1'b0;
            poll_cnt <= '0;
          end else if (poll_en) begin
            poll_cnt <= poll_cnt + PW'(1);
          end
        end

        ST_SETUP: begin
          if (half_end) begin
            hi      <= 1'b0;
            bit_cnt <= '0;
            if (op_is_read(op)) begin
              state <= ST_LOAD;
              r_le  <= 1'b1;
            end else begin
              state  <= ST_SHIFT;
              r_dout <= wsr[7];
              wsr    <= {wsr[6:0], 1'b0};
            end
          end
        end

        ST_LOAD: begin
          if (half_end) begin
            if (!hi) begin
              r_clk <= 1'b1;
              hi    <= 1'b1;
            end else begin
              r_clk <= 1'b0;
              r_le  <= 1'b0;
              hi    <= 1'b0;
              state <= ST_SHIFT;
            end
          end
        end

        ST_SHIFT: begin
          // Bit k appears on r_din after shift pulse k+2; it is taken on
          // the last clk of that pulse's high half, a full half after the
          // CPLD updated it.
          if (sample_slot && hi && op_is_read(op) && (bit_cnt != 4'd0)) begin
            rsr <= {rsr[6:0], r_din};
          end
          if (half_end) begin
            if (!hi) begin
              r_clk <= 1'b1;
              hi    <= 1'b1;
            end else begin
              r_clk <= 1'b0;
              hi    <= 1'b0;
              if (op_is_read(op)) begin
                if (bit_cnt == 4'(READ_PULSES - 1)) begin
                  state <= ST_FIN;
                end else begin
                  bit_cnt <= bit_cnt + 4'd1;
                end
              end else if (bit_cnt == 4'(WRITE_PULSES - 1)) begin
                state  <= ST_LATCH;
                r_le   <= 1'b1;
                r_dout <= 1'b0;
              end else begin
                bit_cnt <= bit_cnt + 4'd1;
                r_dout  <= wsr[7];
                wsr     <= {wsr[6:0], 1'b0};
              end
            end
          end
        end

        ST_LATCH: begin
          if (half_end) begin
            if (!hi) begin
              r_clk <= 1'b1;
              hi    <= 1'b1;
            end else begin
              // r_le drops together with the falling edge.
              r_clk <= 1'b0;
              r_le  <= 1'b0;
              hi    <= 1'b0;
              state <= ST_FIN;
            end
          end
        end

        ST_FIN: begin
          if (op_is_read(op)) begin
            if (host) begin
              cmd_rdata <= rsr;
            end
            if (op == OP_RTC) begin
              tc_last <= rsr;
              if (!host && (rsr != tc_last)) begin
                tc_changed <= 1'b1;
              end
            end
          end
          cmd_done <= host;
          cmd_busy <= 1'b0;
          host     <= 1'b0;
          r_clk    <= 1'b0;
          r_le     <= 1'b0;
          r_dout   <= 1'b0;
          state    <= ST_IDLE;
        end

        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_tipi_reg_seq.sv
// Self-checking bench for tipi_reg_seq with a behavioural model of the
// CPLD side (RC/RD/TC/TD registers, shift register, registered r_din mux).
module tb_tipi_reg_seq;

  localparam int CLK_DIV     = 4;
  localparam int POLL_CYCLES = 16;

  // ---------------------------------------------------------------- clock/reset
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  logic       cmd_req = 1'b0;
  logic [1:0] cmd_op = 2'b00;
  logic [7:0] cmd_wdata = 8'h00;
  logic       poll_en = 1'b0;
  logic       tc_clear = 1'b0;
  logic       cmd_busy, cmd_done, tc_changed;
  logic [7:0] cmd_rdata, tc_last;
  logic       r_clk, r_rt, r_cd, r_le, r_dout, r_din;

  tipi_reg_seq #(
    .CLK_DIV     (CLK_DIV),
    .POLL_CYCLES (POLL_CYCLES)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .cmd_req    (cmd_req),
    .cmd_op     (cmd_op),
    .cmd_wdata  (cmd_wdata),
    .cmd_busy   (cmd_busy),
    .cmd_done   (cmd_done),
    .cmd_rdata  (cmd_rdata),
    .poll_en    (poll_en),
    .tc_changed (tc_changed),
    .tc_clear   (tc_clear),
    .tc_last    (tc_last),
    .r_clk      (r_clk),
    .r_rt       (r_rt),
    .r_cd       (r_cd),
    .r_le       (r_le),
    .r_dout     (r_dout),
    .r_din      (r_din)
  );

  // ---------------------------------------------------------------- CPLD model
  logic [7:0] m_rc = 8'h00, m_rd = 8'h00, m_tc = 8'h00, m_td = 8'h00;
  logic [7:0] m_sr = 8'h00;
  logic       m_pre = 1'b0, m_din = 1'b0;
  assign r_din = m_din;

  // Everything in the CPLD happens on r_clk rise. The output path has two
  // flops, so a loaded MSB reaches r_din after the second shift pulse.
  always @(posedge r_clk) begin
    m_din <= m_pre;
    m_pre <= m_sr[7];
    if (r_le) begin
      if (r_rt) m_sr <= r_cd ? m_td : m_tc;
      else if (r_cd) m_rd <= m_sr;
      else m_rc <= m_sr;
    end else begin
      m_sr <= {m_sr[6:0], r_dout};
    end
  end

  // ---------------------------------------------------------------- monitors
  int cyc = 0, rise_cnt = 0, le_cnt = 0, done_cnt = 0, busy_cnt = 0, hold_viol = 0;
  logic p_rt = 1'b0, p_cd = 1'b0, p_le = 1'b0;
  always @(posedge clk) cyc++;
  always @(posedge r_clk) rise_cnt++;
  always @(posedge r_le) le_cnt++;
  always @(negedge clk) begin
    if (cmd_done) done_cnt++;
    if (cmd_busy) busy_cnt++;
    // Select/qualifier lines must not move while r_clk is high.
    if (r_clk && (r_rt !== p_rt || r_cd !== p_cd || r_le !== p_le)) hold_viol++;
    p_rt = r_rt;
    p_cd = r_cd;
    p_le = r_le;
  end

  // ---------------------------------------------------------------- scoreboard
  int n_checks = 0, n_fail = 0;
  logic [7:0] exp_q[$];
  logic [7:0] exp_rdata = 8'h00, exp_tc_last = 8'h00;
  logic       exp_tcc = 1'b0;
  int acc_cyc = 0, acc_rise = 0, acc_le = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Frame lengths from the protocol: write = SETUP + 8 pulses + LATCH pulse,
  // read = SETUP + LOAD pulse + 9 pulses, plus the FIN cycle.
  function automatic int exp_latency(input logic [1:0] op);
    return (op[1] ? (1 + 2 + 18) : (1 + 16 + 2)) * CLK_DIV + 1;
  endfunction

  function automatic int exp_rises(input logic [1:0] op);
    return op[1] ? 10 : 9;
  endfunction

  // ---------------------------------------------------------------- drivers
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic start_cmd(input logic [1:0] op, input logic [7:0] wd, input int hold,
                           output int waits);
    bit seen;
    seen = 1'b0;
    waits = 0;
    cmd_op = op;
    cmd_wdata = wd;
    cmd_req = 1'b1;
    for (int i = 1; i <= 400 && !seen; i++) begin
      tick(1);
      if (cmd_busy) begin
        seen = 1'b1;
        waits = i;
      end
    end
    acc_cyc = cyc;
    acc_rise = rise_cnt;
    acc_le = le_cnt;
    if (!seen) check("accept_timeout", 32'd0, 32'd1);
    // Keep requesting with junk while busy; none of it may be taken.
    repeat (hold) begin
      cmd_op = 2'($urandom_range(0, 3));
      cmd_wdata = 8'($urandom);
      tick(1);
    end
    cmd_req = 1'b0;
  endtask

  task automatic wait_done(output int lat);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 400 && !seen; i++) begin
      tick(1);
      if (cmd_done) seen = 1'b1;
    end
    lat = cyc - acc_cyc;
    if (!seen) check("done_timeout", 32'd0, 32'd1);
  endtask

  task automatic host_op(input logic [1:0] op, input logic [7:0] wd, input int hold,
                         output int waits);
    int lat, d0;
    logic [7:0] e;
    d0 = done_cnt;
    if (op == 2'b10) exp_q.push_back(m_tc);
    else if (op == 2'b11) exp_q.push_back(m_td);
    start_cmd(op, wd, hold, waits);
    wait_done(lat);
    check("latency", lat, exp_latency(op));
    check("rclk_rises", rise_cnt - acc_rise, exp_rises(op));
    check("le_pulses", le_cnt - acc_le, 1);
    tick(2);
    check("done_count", done_cnt - d0, 1);
    check("busy_clear", cmd_busy, 0);
    if (!op[1]) begin
      check("model_reg", op[0] ? m_rd : m_rc, wd);
      check("rdata_hold", cmd_rdata, exp_rdata);
    end else begin
      e = exp_q.pop_front();
      exp_rdata = e;
      check("rdata", cmd_rdata, e);
      if (!op[0]) exp_tc_last = e;
    end
    check("tc_last", tc_last, exp_tc_last);
    check("tc_changed", tc_changed, exp_tcc);
  endtask

  task automatic check_reset_outputs(input string tag);
    check(tag, {r_clk, r_rt, r_cd, r_le, r_dout, cmd_busy, cmd_done, tc_changed}, 0);
    check({tag, "_data"}, {cmd_rdata, tc_last}, 0);
  endtask

  // ---------------------------------------------------------------- sequence
  initial begin
    int waits, lat, d0, b0, l0;
    logic [1:0] op;
    logic [7:0] wd, old_rd;
    bit seen;

    tick(3);
    check_reset_outputs("reset_state");
    reset_n = 1'b1;
    tick(2);

    // Directed: write RD, read TD, write RC with req held during busy.
    host_op(2'b01, 8'hA5, 0, waits);
    m_td = 8'h3C;
    host_op(2'b11, 8'h00, 0, waits);
    host_op(2'b00, 8'h5A, 10, waits);

    // Random host traffic with the poller off.
    repeat (12) begin
      op = 2'($urandom_range(0, 3));
      wd = 8'($urandom);
      if (op == 2'b10) m_tc = 8'($urandom);
      if (op == 2'b11) m_td = 8'($urandom);
      host_op(op, wd, $urandom_range(0, 5), waits);
    end

    // Reset in the middle of a write (during shift pulse 4).
    old_rd = m_rd;
    start_cmd(2'b01, ~old_rd, 0, waits);
    tick(29);
    reset_n = 1'b0;
    tick(1);
    check_reset_outputs("reset_mid_op");
    reset_n = 1'b1;
    tick(2);
    check("partial_write_dropped", m_rd, old_rd);
    exp_rdata = 8'h00;
    exp_tc_last = 8'h00;
    exp_tcc = 1'b0;
    host_op(2'b01, 8'hFF, 0, waits);

    // Poller: TC changes 00 -> 7E.
    m_tc = 8'h7E;
    d0 = done_cnt;
    b0 = busy_cnt;
    poll_en = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 400 && !seen; i++) begin
      tick(1);
      if (tc_changed) seen = 1'b1;
    end
    check("poll_changed", tc_changed, 1);
    check("poll_tc_last", tc_last, 8'h7E);
    check("poll_no_done", done_cnt - d0, 0);
    check("poll_no_busy", busy_cnt - b0, 0);
    tc_clear = 1'b1;
    tick(1);
    tc_clear = 1'b0;
    check("tc_clear", tc_changed, 0);
    l0 = le_cnt;
    tick(2 * (POLL_CYCLES + 86));
    check("repeat_polls_ran", (le_cnt - l0) >= 2, 1);
    check("repeat_poll_quiet", tc_changed, 0);
    check("repeat_poll_tc_last", tc_last, 8'h7E);

    // Host request on the exact cycle a poll falls due.
    m_tc = 8'h5A;
    seen = 1'b0;
    for (int i = 0; i < 400 && !seen; i++) begin
      tick(1);
      if (tc_changed) seen = 1'b1;
    end
    check("poll2_changed", tc_changed, 1);
    check("poll2_tc_last", tc_last, 8'h5A);
    exp_tc_last = 8'h5A;
    // The poll ended on this edge; the next one is due POLL_CYCLES edges later.
    tick(POLL_CYCLES - 1);
    start_cmd(2'b00, 8'h01, 0, waits);
    check("collide_accept_wait", waits, 1);
    wait_done(lat);
    check("collide_latency", lat, exp_latency(2'b00));
    check("collide_rt_host", r_rt, 0);
    tc_clear = 1'b1;
    tick(1);
    tc_clear = 1'b0;
    check("poll_after_fin", {r_rt, r_cd, cmd_busy}, 3'b100);
    check("collide_model_rc", m_rc, 8'h01);
    exp_tcc = 1'b0;

    // Host request raised while a poll is in its LOAD pulse.
    seen = 1'b0;
    for (int i = 0; i < 50 && !seen; i++) begin
      if (r_le && !cmd_busy) seen = 1'b1;
      else tick(1);
    end
    check("poll_load_seen", seen, 1);
    host_op(2'b10, 8'h00, 0, waits);
    check("req_during_poll_wait", waits, 82);

    check("hold_violations", hold_viol, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
